// File: rtl/audio_serial_tx_pkg.sv
// ============================================================================
// audio_serial_tx_pkg : shared sample format, slot format and FSM encodings
// Revision 1.0
// ============================================================================
`default_nettype none

package audio_serial_tx_pkg;

   // Sample format of the filter chain output, (21,20) signed
   localparam int c_NB_DATA  = 21;
   localparam int c_NBF_DATA = 20;

   // Slot format: left-justified, MSB aligned with the word-select edge
   localparam int   c_NB_SLOT     = 24;
   localparam int   c_CLK_DIV     = 4;
   localparam logic c_SLOT_PAD    = 1'b0;
   localparam logic c_LRCLK_LEFT  = 1'b0;
   localparam logic c_LRCLK_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_bit_timer.sv
// ============================================================================
// serial_bit_timer : bit-clock divider, bit counter and slot-end strobe
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_bit_timer
   import audio_serial_tx_pkg::*;
#(
   parameter int NB_SLOT = c_NB_SLOT,
   parameter int CLK_DIV = c_CLK_DIV,
   localparam int BIT_W  = (NB_SLOT > 1) ? $clog2(NB_SLOT) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   output logic             o_sclk,
   output logic [BIT_W-1:0] o_bit_cnt,
   output logic             o_bit_start,
   output logic             o_slot_end
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] c_DIV_HIGH = DIV_W'(CLK_DIV);
   localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(NB_SLOT - 1);

   logic [DIV_W-1:0] r_div_cnt;
   logic             w_bit_tick;

   assign w_bit_tick  = i_run && (r_div_cnt == c_DIV_LAST);
   assign o_slot_end  = w_bit_tick && (o_bit_cnt == c_BIT_LAST);
   assign o_bit_start = i_run && (r_div_cnt == '0);

   // Counters hold at zero while stopped so the first bit starts on a falling edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_cnt <= '0;
         o_bit_cnt <= '0;
         o_sclk    <= 1'b0;
      end else if (!i_run) begin
         r_div_cnt <= '0;
         o_bit_cnt <= '0;
         o_sclk    <= 1'b0;
      end else begin
         o_sclk <= (r_div_cnt >= c_DIV_HIGH);
         if (w_bit_tick) begin
            r_div_cnt <= '0;
            o_bit_cnt <= (o_bit_cnt == c_BIT_LAST) ? '0 : o_bit_cnt + BIT_W'(1);
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/audio_serial_tx.sv
// ============================================================================
// audio_serial_tx : mono sample serializer to a left-justified L/R DAC stream
// Revision 1.0
// ============================================================================
`default_nettype none

module audio_serial_tx
   import audio_serial_tx_pkg::*;
#(
   parameter int NB_DATA  = c_NB_DATA,
   parameter int NBF_DATA = c_NBF_DATA,
   parameter int NB_SLOT  = c_NB_SLOT,
   parameter int CLK_DIV  = c_CLK_DIV
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic               o_sclk,
   output logic               o_lrclk,
   output logic               o_sdata,
   output logic               o_underrun
);

   localparam int BIT_W = (NB_SLOT > 1) ? $clog2(NB_SLOT) : 1;
   localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(NB_SLOT - 1);

   generate
      if ((NB_SLOT < NB_DATA) || (CLK_DIV < 1) || (NBF_DATA >= NB_DATA)) begin : g_bad_params
         $error("audio_serial_tx: inconsistent NB_DATA/NBF_DATA/NB_SLOT/CLK_DIV");
      end
   endgenerate

   tx_state_t          r_state;
   logic [NB_DATA-1:0] r_hold;
   logic [NB_DATA-1:0] r_frame_sample;
   logic               w_hold_full;
   logic               w_run;
   logic [BIT_W-1:0]   w_bit_cnt;
   logic [BIT_W-1:0]   w_bit_idx;
   logic               w_bit_start;
   logic               w_slot_end;
   logic [NB_SLOT-1:0] w_slot_word;
   logic               w_slot_bit;

   // o_ready doubles as the holding-register empty flag
   assign w_hold_full = !o_ready;
   assign w_run       = (r_state != ST_IDLE);

   serial_bit_timer #(
      .NB_SLOT (NB_SLOT),
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_run       (w_run),
      .o_sclk      (o_sclk),
      .o_bit_cnt   (w_bit_cnt),
      .o_bit_start (w_bit_start),
      .o_slot_end  (w_slot_end)
   );

   always_comb begin
      w_slot_word = {NB_SLOT{c_SLOT_PAD}};
      w_slot_word[NB_SLOT-1 -: NB_DATA] = r_frame_sample;
   end

   assign w_bit_idx  = c_BIT_LAST - w_bit_cnt;
   assign w_slot_bit = w_slot_word[w_bit_idx];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= ST_IDLE;
         r_hold         <= '0;
         r_frame_sample <= '0;
         o_ready        <= 1'b1;
         o_lrclk        <= c_LRCLK_LEFT;
         o_sdata        <= 1'b0;
         o_underrun     <= 1'b0;
      end else begin
         o_underrun <= 1'b0;

         if (i_valid && o_ready) begin
            r_hold  <= i_data;
            o_ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               o_lrclk <= c_LRCLK_LEFT;
               o_sdata <= 1'b0;
               if (w_hold_full) begin
                  r_frame_sample <= r_hold;
                  o_ready        <= 1'b1;
                  r_state        <= ST_LEFT;
               end
            end

            ST_LEFT: begin
               if (w_bit_start) begin
                  o_lrclk <= c_LRCLK_LEFT;
                  o_sdata <= w_slot_bit;
               end
               if (w_slot_end) begin
                  r_state <= ST_RIGHT;
               end
            end

            ST_RIGHT: begin
               if (w_bit_start) begin
                  o_lrclk <= c_LRCLK_RIGHT;
                  o_sdata <= w_slot_bit;
               end
               // Frame boundary: an empty holding register sends a silent frame
               if (w_slot_end) begin
                  r_state <= ST_LEFT;
                  if (w_hold_full) begin
                     r_frame_sample <= r_hold;
                     o_ready        <= 1'b1;
                  end else begin
                     r_frame_sample <= '0;
                     o_underrun     <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_audio_serial_tx.sv
// ============================================================================
// tb_audio_serial_tx : directed checks of audio_serial_tx, NB_SLOT=24, CLK_DIV=2
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_audio_serial_tx;

   localparam int NB_DATA  = 21;
   localparam int NB_SLOT  = 24;
   localparam int CLK_DIV  = 2;
   localparam int BIT_CYC  = 2 * CLK_DIV;
   localparam int SLOT_CYC = NB_SLOT * BIT_CYC;

   logic               i_clk;
   logic               i_rst;
   logic [NB_DATA-1:0] i_data;
   logic               i_valid;
   logic               o_ready;
   logic               o_sclk;
   logic               o_lrclk;
   logic               o_sdata;
   logic               o_underrun;

   int checks = 0;
   int errors = 0;

   audio_serial_tx #(
      .NB_DATA  (NB_DATA),
      .NBF_DATA (20),
      .NB_SLOT  (NB_SLOT),
      .CLK_DIV  (CLK_DIV)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_sclk     (o_sclk),
      .o_lrclk    (o_lrclk),
      .o_sdata    (o_sdata),
      .o_underrun (o_underrun)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int idx);
      chk({tag, "_sclk"},  idx, o_sclk,     1'b0);
      chk({tag, "_lrclk"}, idx, o_lrclk,    1'b0);
      chk({tag, "_sdata"}, idx, o_sdata,    1'b0);
      chk({tag, "_under"}, idx, o_underrun, 1'b0);
      chk({tag, "_ready"}, idx, o_ready,    1'b1);
   endtask

   // Walks one slot cycle by cycle; the last cycle of a slot is where a frame-start
   // edge lands, so ready/underrun get separate expectations there.
   task automatic check_slot(input logic [NB_DATA-1:0] smp, input logic lr,
                             input logic rdy, input logic rdy_last, input logic ur_last,
                             input int n_cyc, input int push_at,
                             input logic [NB_DATA-1:0] push_data);
      logic [NB_SLOT-1:0] word;
      logic               rdy_exp;
      int                 k;
      int                 ph;
      word = '0;
      word[NB_SLOT-1 -: NB_DATA] = smp;
      rdy_exp = rdy;
      for (int i = 0; i < n_cyc; i++) begin
         k  = i / BIT_CYC;
         ph = i % BIT_CYC;
         chk("sdata", i, o_sdata, word[NB_SLOT-1-k]);
         chk("lrclk", i, o_lrclk, lr);
         chk("sclk",  i, o_sclk,  (ph >= CLK_DIV));
         chk("ready", i, o_ready, (i == SLOT_CYC-1) ? rdy_last : rdy_exp);
         chk("underrun", i, o_underrun, (i == SLOT_CYC-1) ? ur_last : 1'b0);
         if (i == push_at) begin
            i_data  = push_data;
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            rdy_exp = 1'b0;
         end else begin
            tick();
         end
      end
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;

      // Reset state and quiet idle
      repeat (3) tick();
      chk_idle("rst", 0);
      i_rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         chk_idle("idle", i);
      end

      // Single sample from IDLE: MSB two cycles after the accept edge
      i_data  = 21'h100001;
      i_valid = 1'b1;
      chk("push1_ready", 0, o_ready, 1'b1);
      tick();
      i_valid = 1'b0;
      chk("acc_ready", 0, o_ready, 1'b0);
      chk("acc_sdata", 0, o_sdata, 1'b0);
      tick();
      chk("xfer_ready", 0, o_ready, 1'b1);
      chk("xfer_sdata", 0, o_sdata, 1'b0);
      chk("xfer_sclk",  0, o_sclk,  1'b0);
      tick();
      check_slot(21'h100001, 1'b0, 1'b1, 1'b1, 1'b0, SLOT_CYC, -1, '0);
      check_slot(21'h100001, 1'b1, 1'b1, 1'b1, 1'b1, SLOT_CYC, -1, '0);

      // Underrun frame is silent; a push mid right slot lands in the next frame
      check_slot('0, 1'b0, 1'b1, 1'b1, 1'b0, SLOT_CYC, -1, '0);
      check_slot('0, 1'b1, 1'b1, 1'b1, 1'b0, SLOT_CYC, 50, 21'h0ABCDE);

      // Asynchronous reset at bit 10 of the left slot
      check_slot(21'h0ABCDE, 1'b0, 1'b1, 1'b1, 1'b0, 10 * BIT_CYC + 2, -1, '0);
      chk("pre_rst_sclk",  0, o_sclk,  1'b1);
      chk("pre_rst_sdata", 0, o_sdata, 1'b1);
      #2;
      i_rst = 1'b1;
      #1;
      chk_idle("async_rst", 0);
      repeat (3) tick();
      i_rst = 1'b0;
      tick();
      chk_idle("post_rst", 0);

      // Back-to-back pushes, third held off until the frame boundary
      i_data  = 21'h0FFFFF;
      i_valid = 1'b1;
      chk("b2b_ready0", 0, o_ready, 1'b1);
      tick();
      chk("b2b_ready1", 0, o_ready, 1'b0);
      i_data = 21'h155555;
      tick();
      chk("b2b_ready2", 0, o_ready, 1'b1);
      chk("b2b_sdata2", 0, o_sdata, 1'b0);
      tick();
      i_data = 21'h1F0F0F;
      check_slot(21'h0FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, SLOT_CYC, -1, '0);
      check_slot(21'h0FFFFF, 1'b1, 1'b0, 1'b1, 1'b0, SLOT_CYC, -1, '0);
      i_valid = 1'b0;
      check_slot(21'h155555, 1'b0, 1'b0, 1'b0, 1'b0, SLOT_CYC, -1, '0);
      check_slot(21'h155555, 1'b1, 1'b0, 1'b1, 1'b0, SLOT_CYC, -1, '0);
      check_slot(21'h1F0F0F, 1'b0, 1'b1, 1'b1, 1'b0, SLOT_CYC, -1, '0);
      check_slot(21'h1F0F0F, 1'b1, 1'b1, 1'b1, 1'b1, SLOT_CYC, -1, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
